// File: rtl/fp_pkg.sv
// Shared FP64 constants and the request/in-flight record layouts used by the
// dispatch stage and its FIFOs.
package fp_pkg;

    localparam int precision_LEN = 64;
    localparam int exp_LEN       = 11;
    localparam int frac_LEN      = 52;
    localparam int op_LEN        = 4;
    localparam int tag_LEN       = 4;

    typedef struct packed {
        logic [precision_LEN-1:0] a;
        logic [precision_LEN-1:0] b;
        logic [op_LEN-1:0]        op;
        logic [tag_LEN-1:0]       tag;
    } cmd_t;

    typedef struct packed {
        logic [op_LEN-1:0]  op;
        logic [tag_LEN-1:0] tag;
    } tag_ent_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter one bit wider than the pointers;
// the head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an empty FIFO masks its head, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Request stage in front of the FP64 controller: queues tagged requests, issues
// them in order and pairs each in-order result with the tag it was issued under.
module fpu_dispatch
    import fp_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int INFLIGHT  = 8
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [precision_LEN-1:0]      req_a,
    input  logic [precision_LEN-1:0]      req_b,
    input  logic [op_LEN-1:0]             req_op,
    input  logic [tag_LEN-1:0]            req_tag,
    output logic [precision_LEN-1:0]      fpu_a,
    output logic [precision_LEN-1:0]      fpu_b,
    output logic [op_LEN-1:0]             fpu_op,
    output logic                          fpu_enable,
    input  logic                          fpu_busy,
    input  logic                          fpu_valid,
    input  logic [precision_LEN-1:0]      fpu_result,
    output logic                          rsp_valid,
    output logic [precision_LEN-1:0]      rsp_result,
    output logic [op_LEN-1:0]             rsp_op,
    output logic [tag_LEN-1:0]            rsp_tag,
    output logic [$clog2(INFLIGHT+1)-1:0] inflight_cnt,
    output logic                          err_orphan
);

    localparam int CMD_CW = $clog2(CMD_DEPTH+1);
    localparam int TAG_CW = $clog2(INFLIGHT+1);

    cmd_t               cmd_in;
    cmd_t               cmd_head;
    logic [CMD_CW-1:0]  cmd_count;
    logic               cmd_full;
    logic               cmd_empty;
    tag_ent_t           tag_in;
    tag_ent_t           tag_head;
    logic               tag_full;
    logic               tag_empty;
    logic               accept;
    logic               issue;
    logic               do_return;
    logic               orphan;

    assign cmd_full  = (cmd_count == CMD_CW'(CMD_DEPTH));
    assign cmd_empty = (cmd_count == '0);
    assign tag_full  = (inflight_cnt == TAG_CW'(INFLIGHT));
    assign tag_empty = (inflight_cnt == '0);

    // A full command FIFO refuses even when it pops this cycle.
    assign req_ready  = srstn && !cmd_full;
    assign accept     = req_valid && req_ready;
    assign fpu_enable = !cmd_empty && !tag_full;
    assign issue      = fpu_enable && !fpu_busy;
    assign do_return  = fpu_valid && !tag_empty;
    assign orphan     = fpu_valid && tag_empty;

    assign cmd_in = '{a: req_a, b: req_b, op: req_op, tag: req_tag};
    assign tag_in = '{op: cmd_head.op, tag: cmd_head.tag};

    assign fpu_a  = cmd_head.a;
    assign fpu_b  = cmd_head.b;
    assign fpu_op = cmd_head.op;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .srstn (srstn),
        .push  (accept),
        .wdata (cmd_in),
        .pop   (issue),
        .rdata (cmd_head),
        .count (cmd_count)
    );

    sync_fifo #(
        .WIDTH ($bits(tag_ent_t)),
        .DEPTH (INFLIGHT)
    ) u_tag_fifo (
        .clk   (clk),
        .srstn (srstn),
        .push  (issue),
        .wdata (tag_in),
        .pop   (do_return),
        .rdata (tag_head),
        .count (inflight_cnt)
    );

    always_ff @(posedge clk) begin
        if (!srstn) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_tag    <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= do_return;
            if (do_return) begin
                rsp_result <= fpu_result;
                rsp_op     <= tag_head.op;
                rsp_tag    <= tag_head.tag;
            end
            if (orphan) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: table-driven ops, directed corner cases,
// and a negedge scoreboard tracking issue order and response pairing.
module tb_fpu_dispatch;
    import fp_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int INFLIGHT  = 8;
    localparam int CW        = $clog2(INFLIGHT+1);

    logic                     clk = 1'b0;
    logic                     srstn = 1'b0;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic [precision_LEN-1:0] req_a = '0;
    logic [precision_LEN-1:0] req_b = '0;
    logic [op_LEN-1:0]        req_op = '0;
    logic [tag_LEN-1:0]       req_tag = '0;
    logic [precision_LEN-1:0] fpu_a;
    logic [precision_LEN-1:0] fpu_b;
    logic [op_LEN-1:0]        fpu_op;
    logic                     fpu_enable;
    logic                     fpu_busy = 1'b0;
    logic                     fpu_valid = 1'b0;
    logic [precision_LEN-1:0] fpu_result = '0;
    logic                     rsp_valid;
    logic [precision_LEN-1:0] rsp_result;
    logic [op_LEN-1:0]        rsp_op;
    logic [tag_LEN-1:0]       rsp_tag;
    logic [CW-1:0]            inflight_cnt;
    logic                     err_orphan;

    fpu_dispatch #(.CMD_DEPTH(CMD_DEPTH), .INFLIGHT(INFLIGHT)) dut (
        .clk(clk), .srstn(srstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_enable(fpu_enable), .fpu_busy(fpu_busy),
        .fpu_valid(fpu_valid), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .inflight_cnt(inflight_cnt), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct packed {
        logic [63:0] result;
        logic [3:0]  op;
        logic [3:0]  tag;
    } rsp_exp_t;

    cmd_t       cmd_q[$];
    cmd_t       fly_q[$];
    rsp_exp_t   rsp_q[$];
    logic [3:0] issue_log[$];
    cmd_t       mon_c;
    rsp_exp_t   mon_r;

    // Inputs change 2 time units after posedge; everything is sampled at negedge.
    always @(negedge clk) begin
        if (rsp_q.size() > 0) begin
            mon_r = rsp_q.pop_front();
            check("rsp_valid", rsp_valid, 1);
            check("rsp_result", rsp_result, mon_r.result);
            check("rsp_op", rsp_op, mon_r.op);
            check("rsp_tag", rsp_tag, mon_r.tag);
        end else if (rsp_valid) begin
            check("rsp_spurious", rsp_valid, 0);
        end
        if (!srstn) begin
            cmd_q.delete();
            fly_q.delete();
        end else begin
            if (fpu_valid && fly_q.size() > 0) begin
                mon_c = fly_q.pop_front();
                rsp_q.push_back('{result: fpu_result, op: mon_c.op, tag: mon_c.tag});
            end
            if (fpu_enable && !fpu_busy) begin
                if (cmd_q.size() == 0) begin
                    check("issue_spurious", fpu_enable, 0);
                end else begin
                    mon_c = cmd_q.pop_front();
                    check("issue_a", fpu_a, mon_c.a);
                    check("issue_b", fpu_b, mon_c.b);
                    check("issue_op", fpu_op, mon_c.op);
                    fly_q.push_back(mon_c);
                    issue_log.push_back(mon_c.tag);
                end
            end
            if (req_valid && req_ready)
                cmd_q.push_back('{a: req_a, b: req_b, op: req_op, tag: req_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic [3:0] tag);
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        for (int i = 0; i < 64 && !req_ready; i++) tick();
        if (!req_ready) check("send_timeout", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_inflight(input int n);
        for (int i = 0; i < 64 && inflight_cnt != CW'(n); i++) tick();
        check("wait_inflight", inflight_cnt, n);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (inflight_cnt != 0 || fpu_enable); i++) begin
            fpu_valid  = (inflight_cnt != 0);
            fpu_result = {32'hD0D0_0000, 32'(i)};
            tick();
        end
        fpu_valid = 1'b0;
        tick();
        check("drain_done", inflight_cnt, 0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [3:0]  tag;
        logic [63:0] result;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{64'h3FF0000000000000, 64'h4000000000000000, 4'h0, 4'h3, 64'h4008000000000000};
        vecs[1] = '{64'hC000000000000000, 64'h3FE0000000000000, 4'h1, 4'hE, 64'hBFF0000000000000};
        vecs[2] = '{64'h7FEFFFFFFFFFFFFF, 64'h0000000000000001, 4'h2, 4'h0, 64'h7FF0000000000000};
        vecs[3] = '{64'h0000000000000000, 64'h8000000000000000, 4'h3, 4'hF, 64'h0000000000000000};
        vecs[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 4'hF, 4'h7, 64'h5555555555555555};
        vecs[5] = '{64'h4024000000000000, 64'h4014000000000000, 4'h8, 4'h9, 64'h4000000000000000};

        // Reset values
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_fpu_enable", fpu_enable, 0);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_fpu_b", fpu_b, 0);
        check("rst_fpu_op", fpu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_inflight", inflight_cnt, 0);
        check("rst_err_orphan", err_orphan, 0);
        srstn = 1'b1;
        tick();
        check("rel_req_ready", req_ready, 1);

        // Single op
        req_a = 64'h3FF0000000000000; req_b = 64'h4000000000000000;
        req_op = 4'h0; req_tag = 4'h5; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("single_enable", fpu_enable, 1);
        check("single_head_a", fpu_a, 64'h3FF0000000000000);
        tick();
        check("single_enable_off", fpu_enable, 0);
        check("single_inflight", inflight_cnt, 1);
        fpu_valid = 1'b1; fpu_result = 64'h4008000000000000;
        tick();
        fpu_valid = 1'b0;
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_tag", rsp_tag, 5);
        check("single_rsp_result", rsp_result, 64'h4008000000000000);
        check("single_inflight0", inflight_cnt, 0);
        tick();
        check("single_rsp_pulse", rsp_valid, 0);

        // Table of ops: stream in, then return back-to-back in order
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
        wait_inflight(6);
        for (int i = 0; i < 6; i++) begin
            fpu_valid = 1'b1; fpu_result = vecs[i].result;
            tick();
            check("vec_rsp_tag", rsp_tag, vecs[i].tag);
            check("vec_rsp_op", rsp_op, vecs[i].op);
            check("vec_rsp_result", rsp_result, vecs[i].result);
        end
        fpu_valid = 1'b0;
        tick();
        check("vec_inflight0", inflight_cnt, 0);

        // Backpressure: busy holds the head, 5th request refused
        fpu_busy = 1'b1;
        issue_log.delete();
        for (int i = 0; i < 5; i++) begin
            req_a = 64'(256 + i); req_b = 64'(512 + i); req_op = 4'h2; req_tag = 4'(i);
            req_valid = 1'b1;
            check(i < 4 ? "bp_ready" : "bp_ready_full", req_ready, (i < 4) ? 1 : 0);
            tick();
        end
        req_valid = 1'b0;
        check("bp_enable", fpu_enable, 1);
        check("bp_head_a", fpu_a, 64'h100);
        tick(); tick();
        check("bp_head_stable", fpu_a, 64'h100);
        check("bp_no_issue", issue_log.size(), 0);
        fpu_busy = 1'b0;
        repeat (6) tick();
        check("bp_issue_count", issue_log.size(), 4);
        for (int j = 0; j < issue_log.size() && j < 4; j++)
            check("bp_issue_order", issue_log[j], j);
        check("bp_inflight", inflight_cnt, 4);
        drain();

        // In-flight full: nothing returns
        issue_log.delete();
        for (int i = 0; i < 10; i++) send(64'(4096 + i), 64'(i), 4'h4, 4'(i));
        tick(); tick();
        check("full_inflight", inflight_cnt, 8);
        check("full_enable", fpu_enable, 0);
        check("full_issue_count", issue_log.size(), 8);
        fpu_valid = 1'b1; fpu_result = 64'h1234;
        tick();
        fpu_valid = 1'b0;
        check("full_reenable", fpu_enable, 1);
        check("full_inflight7", inflight_cnt, 7);
        tick();
        check("full_refill", inflight_cnt, 8);
        drain();

        // Same-cycle issue and return at count 3
        send(64'hA, 64'h1, 4'h1, 4'hA);
        send(64'hB, 64'h2, 4'h1, 4'hB);
        send(64'hC, 64'h3, 4'h1, 4'hC);
        wait_inflight(3);
        req_a = 64'hD; req_b = 64'h4; req_op = 4'h6; req_tag = 4'hD; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("same_enable", fpu_enable, 1);
        fpu_valid = 1'b1; fpu_result = 64'hAAAA;
        tick();
        fpu_valid = 1'b0;
        check("same_inflight", inflight_cnt, 3);
        check("same_rsp_tag", rsp_tag, 4'hA);
        for (int i = 0; i < 3; i++) begin
            fpu_valid = 1'b1; fpu_result = 64'(i);
            tick();
            check("same_order", rsp_tag, 4'hB + 4'(i));
        end
        fpu_valid = 1'b0;
        tick();
        check("same_inflight0", inflight_cnt, 0);

        // Orphan
        check("orphan_pre", err_orphan, 0);
        fpu_valid = 1'b1; fpu_result = 64'hDEAD;
        tick();
        fpu_valid = 1'b0;
        check("orphan_set", err_orphan, 1);
        check("orphan_no_rsp", rsp_valid, 0);
        tick(); tick();
        check("orphan_sticky", err_orphan, 1);

        // Reset mid-operation: 3 in flight, 2 queued
        send(64'h11, 64'h1, 4'h3, 4'h1);
        send(64'h22, 64'h2, 4'h3, 4'h2);
        send(64'h33, 64'h3, 4'h3, 4'h3);
        wait_inflight(3);
        fpu_busy = 1'b1;
        send(64'h44, 64'h4, 4'h3, 4'h4);
        send(64'h55, 64'h5, 4'h3, 4'h5);
        check("mid_enable", fpu_enable, 1);
        srstn = 1'b0;
        tick();
        check("mid_req_ready", req_ready, 0);
        check("mid_enable_rst", fpu_enable, 0);
        check("mid_fpu_a", fpu_a, 0);
        check("mid_fpu_op", fpu_op, 0);
        check("mid_inflight", inflight_cnt, 0);
        check("mid_rsp_result", rsp_result, 0);
        check("mid_rsp_tag", rsp_tag, 0);
        check("mid_err_orphan", err_orphan, 0);
        srstn = 1'b1;
        fpu_busy = 1'b0;
        tick();
        check("mid_release_ready", req_ready, 1);
        fpu_valid = 1'b1; fpu_result = 64'hBEEF;
        tick();
        fpu_valid = 1'b0;
        check("post_rst_orphan", err_orphan, 1);
        check("post_rst_no_rsp", rsp_valid, 0);

        repeat (3) tick();
        check("sb_empty", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
